// File: rtl/mem_pkg.sv
// Shared types and encodings for the load/store split sequencer.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ_LO  = 3'd1,
      WAIT_LO = 3'd2,
      REQ_HI  = 3'd3,
      WAIT_HI = 3'd4
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [7:0] ALIGN_EXC_DEF = 8'h84;

   // An access crosses a word boundary when its last byte lands past lane 3.
   function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_WORD) && (off != 2'd0)) ||
             ((size == SZ_HALF) && (off == 2'd3));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: store byte-enables/data shift and load extract/sign-extend.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic        hi_beat,
   input  logic [31:0] wdata,
   input  logic [31:0] lo_data,
   input  logic [31:0] hi_data,
   output logic [3:0]  we,
   output logic [31:0] wlane,
   output logic [31:0] rdata
);

   logic [3:0]  size_mask;
   logic [7:0]  mask8;
   logic [63:0] d64;
   logic [31:0] w32;

   always_comb begin
      size_mask = 4'b1111;
      case (size)
         SZ_BYTE: size_mask = 4'b0001;
         SZ_HALF: size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   end

   assign mask8 = {4'b0000, size_mask} << off;
   assign d64   = {32'd0, wdata} << {off, 3'b000};
   assign we    = hi_beat ? mask8[7:4] : mask8[3:0];
   assign wlane = hi_beat ? d64[63:32] : d64[31:0];

   // Only the low word of the shifted pair can hold result bytes.
   assign w32 = 32'({hi_data, lo_data} >> {off, 3'b000});

   always_comb begin
      rdata = w32;
      case (size)
         SZ_BYTE: rdata = {{24{sgn & w32[7]}}, w32[7:0]};
         SZ_HALF: rdata = {{16{sgn & w32[15]}}, w32[15:0]};
         default: rdata = w32;
      endcase
   end

endmodule

// File: rtl/mem_split_ctrl.sv
// Load/store sequencer issuing one or two aligned word beats per request.
// Optional MEM_SPLIT_ALIGN_TRAP_EN: word-crossing requests trap instead of splitting.
module mem_split_ctrl
   import mem_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter logic [7:0]  ALIGN_EXC = ALIGN_EXC_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              flush,
   output logic              mem_req,
   input  logic              mem_ready,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [7:0]        rsp_exc,
   output logic              stall_out
);

`ifdef MEM_SPLIT_ALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              sgn_q, store_q, flushed_q;
   logic [31:0]       wdata_q, lo_buf_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic [7:0]        rsp_exc_q;

   logic              accept, done, latch_lo, hi_beat, split, trap;
   logic [ADDR_W-1:0] word_addr, hi_addr;
   logic [3:0]        lane_we;
   logic [31:0]       lane_wdata, lane_rdata, lo_in, hi_in;

   assign split     = is_split(size_q, addr_q[1:0]);
   assign trap      = TRAP_EN && split;
   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign hi_addr   = word_addr + ADDR_W'(4);

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      done     = 1'b0;
      latch_lo = 1'b0;
      mem_req  = 1'b0;
      hi_beat  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            if (trap) begin
               done = 1'b1;
            end else begin
               mem_req = 1'b1;
               // A beat taken in the same cycle as flush has already reached memory.
               if (mem_ready) begin
                  if (!store_q)   state_d = WAIT_LO;
                  else if (split) state_d = REQ_HI;
                  else            done    = 1'b1;
               end else if (flush) begin
                  state_d = IDLE;
               end
            end
         end
         WAIT_LO: begin
            if (mem_rvalid) begin
               latch_lo = 1'b1;
               if (split) state_d = REQ_HI;
               else       done    = 1'b1;
            end
         end
         REQ_HI: begin
            mem_req = 1'b1;
            hi_beat = 1'b1;
            if (mem_ready) begin
               if (store_q) done    = 1'b1;
               else         state_d = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (mem_rvalid) done = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (done) state_d = IDLE;
   end

   assign lo_in = (state_q == WAIT_LO) ? mem_rdata : lo_buf_q;
   assign hi_in = (state_q == WAIT_HI) ? mem_rdata : 32'd0;

   mem_lane_align u_lane (
      .off     (addr_q[1:0]),
      .size    (size_q),
      .sgn     (sgn_q),
      .hi_beat (hi_beat),
      .wdata   (wdata_q),
      .lo_data (lo_in),
      .hi_data (hi_in),
      .we      (lane_we),
      .wlane   (lane_wdata),
      .rdata   (lane_rdata)
   );

   logic rsp_fire;
   assign rsp_fire = done && !(flushed_q || flush);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= SZ_BYTE;
         sgn_q       <= 1'b0;
         store_q     <= 1'b0;
         wdata_q     <= '0;
         lo_buf_q    <= '0;
         flushed_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_exc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr;
            size_q  <= (req_size == 2'd3) ? SZ_WORD : req_size;
            sgn_q   <= req_signed;
            store_q <= req_is_store;
            wdata_q <= req_wdata;
         end
         if (latch_lo) lo_buf_q <= mem_rdata;
         flushed_q   <= accept ? 1'b0 : (flushed_q | (flush && (state_q != IDLE)));
         rsp_valid_q <= rsp_fire;
         rsp_rdata_q <= (rsp_fire && !store_q && !trap) ? lane_rdata : 32'd0;
         rsp_exc_q   <= (rsp_fire && trap) ? ALIGN_EXC : 8'd0;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign stall_out = (state_q != IDLE);
   assign mem_addr  = hi_beat ? hi_addr : word_addr;
   assign mem_we    = (mem_req && store_q) ? lane_we : 4'b0000;
   assign mem_wdata = lane_wdata;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_exc   = rsp_exc_q;

endmodule

// File: tb/tb_mem_split_ctrl.sv
// Scoreboard bench for mem_split_ctrl: expected beats/responses queued by the driver, popped by a monitor.
module tb_mem_split_ctrl;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
   } beat_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [7:0]  exc;
   } rsp_t;

`ifdef MEM_SPLIT_ALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_is_store, req_signed, flush;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req, mem_ready, mem_rvalid;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        rsp_valid, stall_out;
   logic [31:0] rsp_rdata;
   logic [7:0]  rsp_exc;

   beat_t       exp_beat_q[$];
   rsp_t        exp_rsp_q[$];
   logic [31:0] rd_q[$];

   int checks = 0;
   int errors = 0;

   mem_split_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .flush(flush),
      .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc),
      .stall_out(stall_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic acc_load;
   always @(posedge clk) begin
      acc_load = rst_n && mem_req && mem_ready && (mem_we == 4'b0000);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (acc_load && rd_q.size() > 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rd_q.pop_front();
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req && mem_ready) begin
            if (exp_beat_q.size() == 0) check("unexpected_beat", 96'(mem_addr), 96'hDEAD);
            else check("beat", 96'({mem_addr, mem_we, mem_wdata}), 96'(exp_beat_q.pop_front()));
         end
         if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) check("unexpected_rsp", 96'(rsp_rdata), 96'hDEAD);
            else check("rsp", 96'({rsp_rdata, rsp_exc}), 96'(exp_rsp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) check("issue_timeout", 96'(req_ready), 96'd1);
      req_valid = 1'b1; req_is_store = st; req_size = sz;
      req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) check("done_timeout", 96'(req_ready), 96'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic exp_beat(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      beat_t b;
      b.addr = a; b.we = we; b.wdata = wd;
      exp_beat_q.push_back(b);
   endtask

   task automatic exp_rsp(input logic [31:0] rd, input logic [7:0] ex);
      rsp_t r;
      r.rdata = rd; r.exc = ex;
      exp_rsp_q.push_back(r);
   endtask

   // Split load: either two beats with data, or a trap with no beats.
   task automatic split_load(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                             input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] res);
      if (TRAP) begin
         exp_rsp(32'h0, 8'h84);
      end else begin
         rd_q.push_back(lo); rd_q.push_back(hi);
         exp_beat({a[31:2], 2'b00}, 4'b0000, 32'h0);
         exp_beat({a[31:2], 2'b00} + 32'd4, 4'b0000, 32'h0);
         exp_rsp(res, 8'h00);
      end
      issue(1'b0, sz, sg, a, 32'h0);
      wait_done();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 96'(req_ready), 96'd1);
      check("rst_outputs", 96'({mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, stall_out}), 96'd0);
      check("rst_rsp", 96'({rsp_rdata, rsp_exc}), 96'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Aligned word load with latency checks
      rd_q.push_back(32'hDEADBEEF);
      exp_beat(32'h100, 4'b0000, 32'h0);
      exp_rsp(32'hDEADBEEF, 8'h00);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      check("t1_stall_c1", 96'({stall_out, rsp_valid}), 96'b10);
      @(posedge clk); #1;
      check("t1_stall_c2", 96'({stall_out, rsp_valid}), 96'b10);
      @(posedge clk); #1;
      check("t1_rsp_c3", 96'({stall_out, rsp_valid, req_ready}), 96'b011);
      wait_done();

      split_load(2'd2, 1'b0, 32'h101, 32'h44332211, 32'h88776655, 32'h55443322);
      split_load(2'd1, 1'b1, 32'h103, 32'h80112233, 32'h445566FF, 32'hFFFFFF80);
      split_load(2'd1, 1'b0, 32'h103, 32'h80112233, 32'h445566FF, 32'h0000FF80);
      split_load(2'd2, 1'b0, 32'hFFFFFFFD, 32'hAABBCCDD, 32'h11223344, 32'h44AABBCC);

      // Split word store
      if (TRAP) exp_rsp(32'h0, 8'h84);
      else begin
         exp_beat(32'h100, 4'b1100, 32'hCCDD0000);
         exp_beat(32'h104, 4'b0011, 32'h0000AABB);
         exp_rsp(32'h0, 8'h00);
      end
      issue(1'b1, 2'd2, 1'b0, 32'h102, 32'hAABBCCDD);
      wait_done();

      // Split half store
      if (TRAP) exp_rsp(32'h0, 8'h84);
      else begin
         exp_beat(32'h400, 4'b1000, 32'h34000000);
         exp_beat(32'h404, 4'b0001, 32'h00000012);
         exp_rsp(32'h0, 8'h00);
      end
      issue(1'b1, 2'd1, 1'b0, 32'h403, 32'h00001234);
      wait_done();

      // Non-split accesses behave the same in every build
      rd_q.push_back(32'h00F50000);
      exp_beat(32'h200, 4'b0000, 32'h0); exp_rsp(32'hFFFFFFF5, 8'h00);
      issue(1'b0, 2'd0, 1'b1, 32'h202, 32'h0); wait_done();

      exp_beat(32'h300, 4'b1000, 32'h5A000000); exp_rsp(32'h0, 8'h00);
      issue(1'b1, 2'd0, 1'b0, 32'h303, 32'hFFFFFF5A); wait_done();

      exp_beat(32'h300, 4'b0110, 32'h00BEEF00); exp_rsp(32'h0, 8'h00);
      issue(1'b1, 2'd1, 1'b0, 32'h301, 32'h0000BEEF); wait_done();

      rd_q.push_back(32'h9ABC1234);
      exp_beat(32'h500, 4'b0000, 32'h0); exp_rsp(32'h00009ABC, 8'h00);
      issue(1'b0, 2'd1, 1'b0, 32'h502, 32'h0); wait_done();

      rd_q.push_back(32'h9ABC1234);
      exp_beat(32'h500, 4'b0000, 32'h0); exp_rsp(32'hFFFF9ABC, 8'h00);
      issue(1'b0, 2'd1, 1'b1, 32'h502, 32'h0); wait_done();

      rd_q.push_back(32'h01020304);
      exp_beat(32'h600, 4'b0000, 32'h0); exp_rsp(32'h01020304, 8'h00);
      issue(1'b0, 2'd3, 1'b0, 32'h600, 32'h0); wait_done();

      // Memory backpressure: request must hold steady
      mem_ready = 1'b0;
      rd_q.push_back(32'h0BADF00D);
      exp_beat(32'h700, 4'b0000, 32'h0); exp_rsp(32'h0BADF00D, 8'h00);
      issue(1'b0, 2'd2, 1'b0, 32'h700, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_req", 96'({mem_req, mem_addr, stall_out}), 96'({1'b1, 32'h700, 1'b1}));
      mem_ready = 1'b1;
      wait_done();

      // Flush before the lo beat is taken: nothing happens
      mem_ready = 1'b0;
      issue(1'b1, 2'd2, 1'b0, 32'h800, 32'h12345678);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; mem_ready = 1'b1;
      check("flush_lo_idle", 96'({req_ready, mem_req}), 96'b10);
      repeat (3) @(posedge clk);
      #1;

      // Flush after the lo store beat: hi beat still issued, no response
      if (TRAP) exp_rsp(32'h0, 8'h84);
      else begin
         exp_beat(32'h900, 4'b1100, 32'hCCDD0000);
         exp_beat(32'h904, 4'b0011, 32'h0000AABB);
      end
      issue(1'b1, 2'd2, 1'b0, 32'h902, 32'hAABBCCDD);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_done();

      check("beats_drained", 96'(exp_beat_q.size()), 96'd0);
      check("rsps_drained", 96'(exp_rsp_q.size()), 96'd0);
      check("rdata_drained", 96'(rd_q.size()), 96'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
